// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic two-entry skid pipeline stage with flush, stall and backpressure counter
module pipe_stage_elastic #(
  parameter int DATA_W        = 32,
  parameter bit ZERO_ON_FLUSH = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bp_cycles
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  bp_q;
  logic              push, pop;

  // in_ready looks only at registered state, so out_ready never reaches it combinationally
  assign in_ready  = (state_q != FULL) & ~stall & ~flush;
  assign out_valid = (state_q != EMPTY) & ~stall;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign bp_cycles = bp_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      if (ZERO_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Counter is independent of flush; it only sees the visible backpressure condition
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_q <= '0;
    end else if (out_valid && !out_ready && !(&bp_q)) begin
      bp_q <= bp_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for pipe_stage_elastic (both flush variants)
module tb_pipe_stage_elastic;

  logic       clk = 1'b0;
  logic       rst, flush, stall, in_valid, out_ready;
  logic [7:0] in_data;

  logic       a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [7:0] a_out_data, b_out_data;
  logic [1:0] a_occ, b_occ;
  logic [2:0] a_bp;
  logic [15:0] b_bp;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb[$];
  int         held  = 0;
  int         bp3   = 0;
  int         bp16  = 0;
  logic [7:0] head1 = 8'h00;
  logic [7:0] head0 = 8'h00;
  bit         armed = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(8), .ZERO_ON_FLUSH(1'b1), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .bp_cycles(a_bp)
  );

  pipe_stage_elastic #(.DATA_W(8), .ZERO_ON_FLUSH(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .bp_cycles(b_bp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle; an accepted payload becomes an expected output immediately
  task automatic cyc(input bit r, input bit f, input bit s, input bit iv,
                     input logic [7:0] d, input bit ordy);
    @(posedge clk);
    #1;
    rst = r; flush = f; stall = s; in_valid = iv; in_data = d; out_ready = ordy;
    #3;
    if (!r && iv && held < 2 && !s && !f) sb.push_back(d);
  endtask

  // Monitor: reference model is a FIFO of at most two entries
  always @(negedge clk) begin
    bit exp_ir, exp_ov, push, pop;
    logic [7:0] exp_d;
    exp_ir = (held < 2) && !stall && !flush;
    exp_ov = (held > 0) && !stall;
    push   = in_valid && exp_ir && !rst;
    pop    = exp_ov && out_ready;
    if (armed) begin
      chk("in_ready_a", 32'(a_in_ready), 32'(exp_ir));
      chk("in_ready_b", 32'(b_in_ready), 32'(exp_ir));
      chk("out_valid_a", 32'(a_out_valid), 32'(exp_ov));
      chk("out_valid_b", 32'(b_out_valid), 32'(exp_ov));
      chk("occupancy_a", 32'(a_occ), 32'(held));
      chk("occupancy_b", 32'(b_occ), 32'(held));
      chk("bp_cycles_a", 32'(a_bp), 32'(bp3));
      chk("bp_cycles_b", 32'(b_bp), 32'(bp16));
      chk("head_a", 32'(a_out_data), 32'(head1));
      chk("head_b", 32'(b_out_data), 32'(head0));
      if (pop) begin
        if (sb.size() == 0) begin
          chk("pop_without_expected", 32'(1), 32'(0));
        end else begin
          exp_d = sb.pop_front();
          chk("pop_data_a", 32'(a_out_data), 32'(exp_d));
          chk("pop_data_b", 32'(b_out_data), 32'(exp_d));
        end
      end
    end
    if (rst) begin
      held = 0; sb.delete(); bp3 = 0; bp16 = 0;
      head1 = 8'h00; head0 = 8'h00; armed = 1'b1;
    end else if (armed) begin
      if (exp_ov && !out_ready) begin
        if (bp3 < 7) bp3++;
        if (bp16 < 65535) bp16++;
      end
      if (flush) begin
        held = 0; sb.delete(); head1 = 8'h00;
      end else begin
        held = held + int'(push) - int'(pop);
        if (held > 0) begin
          head1 = sb[0];
          head0 = sb[0];
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    cyc(1, 0, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    // Reset then stream
    cyc(0, 0, 0, 1, 8'h11, 1);
    cyc(0, 0, 0, 1, 8'h22, 1);
    cyc(0, 0, 0, 1, 8'h33, 1);
    cyc(0, 0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 0, 8'h00, 1);
    // Backpressure fill and drain
    cyc(0, 0, 0, 1, 8'h0A, 0);
    cyc(0, 0, 0, 1, 8'h0B, 0);
    cyc(0, 0, 0, 1, 8'h0C, 0);
    cyc(0, 0, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 0, 8'h00, 1);
    // Stall freeze with a pending input
    cyc(0, 0, 0, 1, 8'h05, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 8'h06, 1);
    cyc(0, 0, 0, 1, 8'h06, 1);
    cyc(0, 0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 0, 8'h00, 1);
    // Flush in FULL with an offered payload
    cyc(0, 0, 0, 1, 8'h41, 0);
    cyc(0, 0, 0, 1, 8'h42, 0);
    cyc(0, 1, 0, 1, 8'h77, 0);
    cyc(0, 0, 0, 0, 8'h00, 1);
    cyc(0, 0, 1, 0, 8'h00, 1);
    cyc(0, 1, 1, 1, 8'h78, 1);
    cyc(0, 0, 0, 0, 8'h00, 1);
    // Counter saturation
    cyc(0, 0, 0, 1, 8'h5A, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 0, 8'h00, 1);
    // Reset mid-operation then a normal delivery
    cyc(0, 0, 0, 1, 8'h61, 0);
    cyc(0, 0, 0, 1, 8'h62, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 1, 8'h63, 1);
    cyc(0, 0, 0, 1, 8'h09, 1);
    cyc(0, 0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 0, 8'h00, 1);
    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(199) == 0), ($urandom_range(29) == 0), ($urandom_range(5) == 0),
          ($urandom_range(9) < 7), 8'($urandom), ($urandom_range(9) < 6));
    end
    cyc(0, 0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 0, 8'h00, 1);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline-stage register, the next generation of the fixed EX→MEM latch. It carries an arbitrary-width payload between two pipeline stages using valid/ready handshaking. A two-entry skid buffer keeps full throughput while removing any combinational path from downstream `out_ready` to upstream `in_ready`. Synchronous flush and freeze (stall) controls replace the per-field reset/enable logic, and a saturating backpressure counter is provided for performance analysis.

## Interface
- `DATA_W`, 32, payload width in bits; any value ≥1.
- `ZERO_ON_FLUSH`, 1, when 1, flush zeroes both payload registers; when 0, payload is left untouched and only valid state is cleared.
- `CNT_W`, 16, width of the backpressure counter; ≥1.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous kill of all held entries; priority over everything except `rst`.
- `stall`  in  1  freeze; no transfer on either side while high.
- `in_valid`  in  1  upstream has a payload.
- `in_ready`  out  1  stage can accept a payload.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  stage presents a payload.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  head payload (main register).
- `occupancy`  out  2  entries held: 0, 1 or 2.
- `bp_cycles`  out  CNT_W  saturating count of backpressure cycles.

## Operation
- Storage: `main` (head) and `skid` registers, each DATA_W bits, plus state EMPTY/ONE/FULL.
- Handshake signals:
  - `push = in_valid & in_ready`; `pop = out_valid & out_ready`.
  - `in_ready = (state != FULL) & ~stall & ~flush`.
  - `out_valid = (state != EMPTY) & ~stall`.
  - `out_data = main` regardless of valid.
- Transitions when not `rst` and not `flush`:
  - EMPTY: push → ONE, main←in_data.
  - ONE: push & pop → ONE, main←in_data. push & ~pop → FULL, skid←in_data. pop & ~push → EMPTY.
  - FULL: no push is possible. pop → ONE, main←skid.
  - No push and no pop: hold.
- `stall`: state and payload hold; both handshakes are suppressed.
- `flush`:
  - Next state is EMPTY.
  - A payload offered in the flush cycle is dropped (`in_ready` is already 0).
  - main and skid are zeroed if ZERO_ON_FLUSH=1, otherwise held.
  - `bp_cycles` is unaffected.
  - flush together with stall → flush wins.
- `rst`: state EMPTY; main, skid and `bp_cycles` all zero, regardless of ZERO_ON_FLUSH. Reset mid-operation discards all entries.
- `bp_cycles`:
  - Increments by 1 on every cycle with `out_valid & ~out_ready`, saturating at 2^CNT_W−1.
  - Does not count stall cycles (out_valid is 0 during stall).
- `occupancy`: EMPTY=0, ONE=1, FULL=2.

## Timing
- Latency: a payload pushed at edge N appears on `out_data` with `out_valid` after edge N, with no extra delay through EMPTY.
- Throughput: 1 payload/cycle sustained while `out_ready` = 1.
- `in_ready` depends only on registered state, `stall` and `flush`; it has no combinational dependence on `out_ready` or `in_valid`.
- Order is preserved: the skid entry never overtakes main.
- Reset values of outputs:
  - in_ready=1 (if stall=0 and flush=0).
  - out_valid=0, out_data=0, occupancy=0, bp_cycles=0.
- After backpressure is released, FULL drains in 2 pop cycles. `in_ready` reasserts the cycle after the first pop.
- Simultaneous push and pop in FULL cannot occur (`in_ready`=0).

## Test plan
- Reset then stream: rst 2 cycles; push 0x11,0x22,0x33 on consecutive cycles with out_ready=1 → out_data 0x11,0x22,0x33 on the three following cycles; occupancy stays 1; bp_cycles=0.
- Backpressure fill/drain: push 0xA,0xB with out_ready=0 → occupancy 2, in_ready=0, bp_cycles increments each cycle. Raise out_ready → pops 0xA then 0xB; in_ready returns to 1 after the first pop.
- Stall freeze: in ONE holding 0x5 with stall=1 for 3 cycles and in_valid=1 → out_valid=0, in_ready=0, no accept, bp_cycles unchanged. Drop stall → 0x5 delivered, then the pending input is accepted.
- Flush in FULL: occupancy 2, assert flush with in_valid=1 (0x77) → next cycle occupancy 0 and out_valid=0. out_data=0 with ZERO_ON_FLUSH=1; with ZERO_ON_FLUSH=0 out_data retains the old head. 0x77 is never output.
- Counter saturation: CNT_W=3, hold out_valid with out_ready=0 for 10 cycles → bp_cycles stops at 7.
- Reset mid-operation: FULL with bp_cycles=5, assert rst → next cycle all outputs at reset values; a subsequent push of 0x9 is delivered normally.
